pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline stage register: the next generation of the fixed MEM/WB-style latch. It carries a control field and a data payload between two pipeline stages through a DEPTH-entry FIFO with a valid/ready handshake. This replaces the Ld/Clr stall-and-clear pair with backpressure and flush. It drops in at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) by setting widths.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_stage_mem.sv | 36 +++
 rtl/pipe_stage_buf.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage registers.
//   - default control/payload widths for each stage boundary
//   - count/pointer width derivation for a DEPTH-entry stage buffer
//   - bit positions of the control signals inside the control field
package pipe_pkg;

    // Default widths per stage boundary (control field, payload).
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;   // 32 PC+4 + 32 instruction
    localparam int IDEX_CTRL_W  = 9;
    localparam int IDEX_DATA_W  = 111;  // 3x32 operands/imm + 3x5 register ids
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 69;   // 32 ALUResult + 32 store data + 5 RegDst
    localparam int MEMWB_CTRL_W = 3;
    localparam int MEMWB_DATA_W = 69;   // 32 ReadData + 32 ALUResult + 5 RegDst

    // Legal buffer depth range.
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 16;

    // Bit positions inside the control field.
    localparam int CTRL_REGWRITE_BIT  = 0;
    localparam int CTRL_REGWRITE2_BIT = 1;
    localparam int CTRL_MEMTOREG_BIT  = 2;

    // Width needed to hold an occupancy of 0..depth.
    function automatic int pipe_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to address depth entries (depth >= 2, so at least 1 bit).
    function automatic int pipe_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// pipe_stage_mem: DEPTH x WIDTH storage for one pipeline stage buffer.
// Ports:
//   Clk    - clock, write on rising edge
//   WrEn   - write enable
//   WrAddr - write address
//   WrData - write word
//   RdAddr - asynchronous read address
//   RdData - word at RdAddr
// The array has no reset; occupancy is tracked by the owner.
module pipe_stage_mem
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int WIDTH  = 72,
    parameter int ADDR_W = 1
)(
    input  logic              Clk,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  WrData,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [WIDTH-1:0]  RdData
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Single synchronous write port.
    always_ff @(posedge Clk) begin
        if (WrEn) begin
            mem_r[WrAddr] <= WrData;
        end
    end

    assign RdData = mem_r[RdAddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline stage register (DEPTH-entry FIFO with
// valid/ready handshake and flush) carrying a control field and a payload.
// Ports:
//   Clk                 - clock
//   Rst_n               - synchronous active-low reset (priority over all)
//   Flush               - discard all held entries and the offered one
//   In_Valid/In_Ready   - upstream handshake; In_Ready = not full (registered)
//   In_Ctrl/In_Data     - offered entry
//   Out_Valid/Out_Ready - downstream handshake; Out_Valid = not empty
//   Out_Ctrl/Out_Data   - head entry, forced to zero when empty (bubble)
//   Count               - number of held entries
//   Stall_Cnt           - saturating count of cycles with Out_Valid=1 and
//                         Out_Ready=0; exists only when PIPE_STAGE_STALL_CNT_EN
//                         is defined
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int  CTRL_W = MEMWB_CTRL_W,
    parameter int  DATA_W = MEMWB_DATA_W,
    parameter int  DEPTH  = 2,
    localparam int CNT_W  = pipe_cnt_w(DEPTH)
)(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [CNT_W-1:0]  Count
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]       Stall_Cnt
`endif
);

    localparam int PTR_W  = pipe_ptr_w(DEPTH);
    localparam int WORD_W = CTRL_W + DATA_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wrPtr_r;
    logic [PTR_W-1:0]  rdPtr_r;
    logic [CNT_W-1:0]  count_r;
    logic              inReady_r;
    logic              outValid_r;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  countNext_s;
    logic [WORD_W-1:0] rdWord_s;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign push_s = In_Valid & inReady_r;
    assign pop_s  = outValid_r & Out_Ready;

    // Occupancy after this cycle's handshakes (flush/reset handled in the register).
    always_comb begin
        countNext_s = count_r;
        if (push_s && !pop_s) begin
            countNext_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            countNext_s = count_r - CNT_W'(1);
        end else begin
            countNext_s = count_r;
        end
    end

    // Pointers, count and the registered handshake flags; In_Ready/Out_Valid
    // are precomputed from the next count so neither depends on this cycle's
    // Out_Ready combinationally.
    always_ff @(posedge Clk) begin
        if (!Rst_n || Flush) begin
            wrPtr_r    <= {PTR_W{1'b0}};
            rdPtr_r    <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            inReady_r  <= 1'b1;
            outValid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wrPtr_r <= ptrInc(wrPtr_r);
            end
            if (pop_s) begin
                rdPtr_r <= ptrInc(rdPtr_r);
            end
            count_r    <= countNext_s;
            inReady_r  <= (countNext_s != FULL_CNT);
            outValid_r <= (countNext_s != {CNT_W{1'b0}});
        end
    end

    pipe_stage_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (WORD_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .Clk    (Clk),
        .WrEn   (push_s),
        .WrAddr (wrPtr_r),
        .WrData ({In_Ctrl, In_Data}),
        .RdAddr (rdPtr_r),
        .RdData (rdWord_s)
    );

    // Empty stage presents an all-zero word so downstream sees a bubble.
    always_comb begin
        Out_Ctrl = {CTRL_W{1'b0}};
        Out_Data = {DATA_W{1'b0}};
        if (outValid_r) begin
            Out_Ctrl = rdWord_s[WORD_W-1 -: CTRL_W];
            Out_Data = rdWord_s[DATA_W-1:0];
        end else begin
            Out_Ctrl = {CTRL_W{1'b0}};
            Out_Data = {DATA_W{1'b0}};
        end
    end

    assign In_Ready  = inReady_r;
    assign Out_Valid = outValid_r;
    assign Count     = count_r;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stallCnt_r;

    // Saturating backpressure counter; only reset clears it, flush does not.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stallCnt_r <= 32'd0;
        end else if (outValid_r && !Out_Ready && (stallCnt_r != 32'hFFFF_FFFF)) begin
            stallCnt_r <= stallCnt_r + 32'd1;
        end
    end

    assign Stall_Cnt = stallCnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: instance 0 has DEPTH=2, instance 1 has DEPTH=3.
// A queue-based model is compared against both instances every cycle, and
// directed tests add hand-computed literal expectations.
module tb_pipe_stage_buf;

    localparam int CW = 3;
    localparam int DW = 69;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic                 rstN;
    logic [1:0]           inValid;
    logic [1:0]           outReady;
    logic [1:0]           flush;
    logic [1:0][CW-1:0]   inCtrl;
    logic [1:0][DW-1:0]   inData;
    wire  [1:0]           inReady;
    wire  [1:0]           outValid;
    wire  [1:0][CW-1:0]   outCtrl;
    wire  [1:0][DW-1:0]   outData;
    wire  [1:0][1:0]      count;
`ifdef PIPE_STAGE_STALL_CNT_EN
    wire  [1:0][31:0]     stallCnt;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_stage_buf #(
            .CTRL_W (CW),
            .DATA_W (DW),
            .DEPTH  (g + 2)
        ) u_dut (
            .Clk       (Clk),
            .Rst_n     (rstN),
            .Flush     (flush[g]),
            .In_Valid  (inValid[g]),
            .In_Ready  (inReady[g]),
            .In_Ctrl   (inCtrl[g]),
            .In_Data   (inData[g]),
            .Out_Valid (outValid[g]),
            .Out_Ready (outReady[g]),
            .Out_Ctrl  (outCtrl[g]),
            .Out_Data  (outData[g]),
            .Count     (count[g])
`ifdef PIPE_STAGE_STALL_CNT_EN
            ,
            .Stall_Cnt (stallCnt[g])
`endif
        );
    end

    int   total = 0;
    int   bad   = 0;
    bit   checkOn = 1'b0;
    int   wrapPops = 0;
    ent_t mq [2][$];
    logic [31:0] mStall [2];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Offer an entry on instance k until accepted, bounded by maxWait cycles.
    task automatic send(input int k, input logic [CW-1:0] c, input logic [DW-1:0] d, input int maxWait);
        bit done;
        done = 1'b0;
        inValid[k] = 1'b1;
        inCtrl[k]  = c;
        inData[k]  = d;
        for (int n = 0; n < maxWait && !done; n++) begin
            done = inReady[k];
            tick();
        end
        inValid[k] = 1'b0;
        if (!done) begin
            check($sformatf("send_timeout_u%0d", k), 128'd0, 128'd1);
        end
    endtask

    // Model: FIFO semantics as a plain queue, updated at each rising edge.
    initial begin
        mStall[0] = 32'd0;
        mStall[1] = 32'd0;
        forever begin
            @(posedge Clk);
            for (int k = 0; k < 2; k++) begin
                int   depth;
                bit   pu;
                bit   po;
                ent_t e;
                depth = k + 2;
                pu = inValid[k] && (mq[k].size() < depth);
                po = (mq[k].size() > 0) && outReady[k];
                e.c = inCtrl[k];
                e.d = inData[k];
                if (!rstN) begin
                    mq[k].delete();
                    mStall[k] = 32'd0;
                end else begin
                    if (mq[k].size() > 0 && !outReady[k] && mStall[k] != 32'hFFFF_FFFF) begin
                        mStall[k] = mStall[k] + 32'd1;
                    end
                    if (flush[k]) begin
                        mq[k].delete();
                    end else begin
                        if (po) begin
                            void'(mq[k].pop_front());
                        end
                        if (pu) begin
                            mq[k].push_back(e);
                        end
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge Clk);
            if (checkOn) begin
                for (int k = 0; k < 2; k++) begin
                    bit   ev;
                    ent_t h;
                    ev = (mq[k].size() > 0);
                    h  = ev ? mq[k][0] : '0;
                    check($sformatf("u%0d_out_valid", k), 128'(outValid[k]), 128'(ev));
                    check($sformatf("u%0d_in_ready", k), 128'(inReady[k]), 128'(mq[k].size() < k + 2));
                    check($sformatf("u%0d_count", k), 128'(count[k]), 128'(mq[k].size()));
                    check($sformatf("u%0d_out_ctrl", k), 128'(outCtrl[k]), 128'(h.c));
                    check($sformatf("u%0d_out_data", k), 128'(outData[k]), 128'(h.d));
`ifdef PIPE_STAGE_STALL_CNT_EN
                    check($sformatf("u%0d_stall_cnt", k), 128'(stallCnt[k]), 128'(mStall[k]));
`endif
                end
                // Instance 1 carries only the wrap sequence 100, 101, ...
                if (outValid[1] && outReady[1]) begin
                    check("wrap_order", 128'(outData[1]), 128'(100 + wrapPops));
                    wrapPops++;
                end
            end
        end
    end

    initial begin
        int j;
        int n;
        bit acc;
        rstN     = 1'b0;
        inValid  = 2'b00;
        outReady = 2'b00;
        flush    = 2'b00;
        inCtrl   = '0;
        inData   = '0;
        tick();
        checkOn = 1'b1;
        tick();
        @(negedge Clk);
        check("rst_out_valid", 128'(outValid[0]), 128'd0);
        check("rst_in_ready", 128'(inReady[0]), 128'd1);
        check("rst_count", 128'(count[0]), 128'd0);
        rstN = 1'b1;

        // Single push with immediate consumption.
        outReady[0] = 1'b1;
        inValid[0]  = 1'b1;
        inCtrl[0]   = 3'b101;
        inData[0]   = 69'h1_2345_6789_ABCD_EF01;
        tick();
        inValid[0]  = 1'b0;
        @(negedge Clk);
        check("single_valid", 128'(outValid[0]), 128'd1);
        check("single_ctrl", 128'(outCtrl[0]), 128'(3'b101));
        check("single_data", 128'(outData[0]), 128'(69'h1_2345_6789_ABCD_EF01));
        tick();
        @(negedge Clk);
        check("single_after_valid", 128'(outValid[0]), 128'd0);
        check("single_after_ctrl", 128'(outCtrl[0]), 128'd0);

        // Full with backpressure: third entry held upstream.
        outReady[0] = 1'b0;
        send(0, 3'd1, 69'h11, 4);
        send(0, 3'd2, 69'h22, 4);
        @(negedge Clk);
        check("full_count", 128'(count[0]), 128'd2);
        check("full_in_ready", 128'(inReady[0]), 128'd0);
        inValid[0] = 1'b1;
        inCtrl[0]  = 3'd3;
        inData[0]  = 69'h33;
        tick();
        tick();
        @(negedge Clk);
        check("held_count", 128'(count[0]), 128'd2);
        check("held_head", 128'(outData[0]), 128'h11);
        outReady[0] = 1'b1;
        send(0, 3'd3, 69'h33, 8);
        repeat (4) tick();

        // Streaming: one entry per cycle, occupancy never above 1.
        for (int i = 0; i < 100; i++) begin
            inValid[0] = 1'b1;
            inCtrl[0]  = 3'(i);
            inData[0]  = 69'(i);
            tick();
            @(negedge Clk);
            check("tp_valid", 128'(outValid[0]), 128'd1);
            check("tp_count_le1", 128'(count[0] <= 2'd1), 128'd1);
            check("tp_data", 128'(outData[0]), 128'(i));
        end
        inValid[0] = 1'b0;
        repeat (2) tick();

        // DEPTH=3 wrap with Out_Ready toggling every cycle.
        j = 0;
        n = 0;
        while (j < 10 && n < 100) begin
            inValid[1] = 1'b1;
            inCtrl[1]  = 3'(j);
            inData[1]  = 69'(100 + j);
            acc = inReady[1];
            tick();
            outReady[1] = ~outReady[1];
            if (acc) begin
                j++;
            end
            n++;
        end
        if (j < 10) begin
            check("wrap_send_timeout", 128'(j), 128'd10);
        end
        inValid[1]  = 1'b0;
        outReady[1] = 1'b1;
        repeat (6) tick();
        check("wrap_pops", 128'(wrapPops), 128'd10);

        // Flush beats the simultaneous push.
        outReady[0] = 1'b0;
        send(0, 3'd4, 69'h44, 4);
        send(0, 3'd5, 69'h55, 4);
        @(negedge Clk);
        check("pre_flush_count", 128'(count[0]), 128'd2);
        inValid[0] = 1'b1;
        inCtrl[0]  = 3'd7;
        inData[0]  = 69'hDEAD;
        flush[0]   = 1'b1;
        tick();
        flush[0]   = 1'b0;
        inValid[0] = 1'b0;
        @(negedge Clk);
        check("flush_count", 128'(count[0]), 128'd0);
        check("flush_valid", 128'(outValid[0]), 128'd0);
        outReady[0] = 1'b1;
        repeat (3) tick();
        @(negedge Clk);
        check("flush_dropped", 128'(outValid[0]), 128'd0);

        // Reset mid-stream.
        outReady[0] = 1'b0;
        send(0, 3'd6, 69'h66, 4);
        inValid[0] = 1'b1;
        inData[0]  = 69'h77;
        rstN = 1'b0;
        tick();
        @(negedge Clk);
        check("mid_rst_valid", 128'(outValid[0]), 128'd0);
        check("mid_rst_count", 128'(count[0]), 128'd0);
        check("mid_rst_ready", 128'(inReady[0]), 128'd1);
        check("mid_rst_data", 128'(outData[0]), 128'd0);
        rstN = 1'b1;
        inValid[0] = 1'b0;
        tick();

`ifdef PIPE_STAGE_STALL_CNT_EN
        // Stall counter: 7 stalled cycles, flush keeps it, reset clears it.
        outReady[0] = 1'b0;
        send(0, 3'd1, 69'h99, 4);
        repeat (7) tick();
        @(negedge Clk);
        check("stall_7", 128'(stallCnt[0]), 128'd7);
        outReady[0] = 1'b1;
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        tick();
        @(negedge Clk);
        check("stall_after_flush", 128'(stallCnt[0]), 128'd7);
        rstN = 1'b0;
        tick();
        @(negedge Clk);
        check("stall_rst", 128'(stallCnt[0]), 128'd0);
        rstN = 1'b1;
        tick();
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
